uart_loader: RTL
================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter WORD_BYTES, default 4, bytes per assembled word; legal values 1, 2, 4, 8.
REQ-002 Parameter SIZE_BYTES, default 4, width of the program-size header in bytes; legal values 1..4.
REQ-003 Parameter INTERVAL, default 100, minimum clock cycles between SYNC_BYTE transmissions.
REQ-004 Parameter SYNC_BYTE, default 8'h99, hello byte sent to the host.
REQ-005 Parameter ACK_BYTE, default 8'haa, program-received acknowledge byte.
REQ-006 Parameter BIG_ENDIAN, default 0; 0 places the first received byte in word bits [7:0], 1 places it in the top byte.
REQ-007 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, minimum 2.
REQ-008 clock  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 rx_ready  in  1  one-cycle pulse; rdata holds a valid received byte.
REQ-011 rdata  in  8  received byte.
REQ-012 tx_busy  in  1  UART sender busy.
REQ-013 tx_start  out  1  one-cycle pulse requesting transmission of sdata.
REQ-014 sdata  out  8  byte to transmit; stable from the tx_start cycle until the next tx_start.
REQ-015 word_valid  out  1  FIFO head valid.
REQ-016 word_ready  in  1  consumer accepts the head word this cycle.
REQ-017 word_data  out  8*WORD_BYTES  FIFO head word.
REQ-018 word_is_instr  out  1  head word belongs to the program section (1) or the data section (0).
REQ-019 program_loaded  out  1  high while in DATA.
REQ-020 overrun  out  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-021 State machine SHALL have five states: SYNC, SIZE, PROG, ACK, DATA.
REQ-022 SYNC: interval counter saturates at INTERVAL and never wraps; when counter==INTERVAL and ~tx_busy: pulse tx_start, sdata=SYNC_BYTE, counter cleared.
REQ-023 SYNC: any rx_ready moves to SIZE; that byte is discarded and is not assembled.
REQ-024 SIZE: collect SIZE_BYTES bytes, little-endian regardless of BIG_ENDIAN, into a byte count; then go to PROG, or go directly to ACK when the count is 0.
REQ-025 PROG: each byte decrements the remaining count; a word is pushed when WORD_BYTES bytes are assembled or the count reaches 0.
REQ-026 Partial final program word: missing byte lanes zero-filled; leave PROG after the last byte.
REQ-027 ACK: wait for ~tx_busy, pulse tx_start with sdata=ACK_BYTE, then go to DATA in the same edge.
REQ-028 DATA: full words only are pushed with word_is_instr=0; the state is terminal until reset.
REQ-029 Byte-lane counter SHALL restart at lane 0 on each entry to PROG and to DATA.
REQ-030 Push latency: word_valid high in the cycle after the rx_ready that completes the word, if the FIFO was empty.
REQ-031 Pop occurs when word_valid && word_ready; word_ready while !word_valid is ignored.
REQ-032 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-033 Push to a full FIFO without a same-cycle pop: word dropped, overrun set; remaining behaviour unaffected.
REQ-034 tx_start SHALL never be asserted while tx_busy is high and never on two consecutive cycles.

Reset
REQ-035 Reset SHALL force state=SYNC, counter=0, byte lane=0, count=0, FIFO empty.
REQ-036 Reset SHALL force tx_start=0, sdata=0, word_valid=0, program_loaded=0, overrun=0.
REQ-037 Reset asserted mid-transfer SHALL discard partial words and FIFO contents; the block resumes at SYNC after release.

Structure
REQ-038 Shared package loader_pkg SHALL hold the state enum and the default SYNC_BYTE and ACK_BYTE constants.
REQ-039 Output buffering SHALL be one sub-module, loader_fifo, parametrised by width (8*WORD_BYTES+1) and FIFO_DEPTH.
REQ-040 Counter widths SHALL be derived with $clog2 from the parameters; no fixed 8-bit counters.

Verification
REQ-041 INTERVAL=10, tx_busy=0, no rx -> tx_start pulses with sdata=8'h99 every 11 cycles; with tx_busy held 1 -> no pulses.
REQ-042 Defaults: send 8'h01, header 08 00 00 00, bytes 11 22 33 44 55 66 77 88 -> words 32'h44332211 and 32'h88776655 with word_is_instr=1, then tx_start with sdata=8'haa, program_loaded=1.
REQ-043 Header 06 00 00 00, bytes 11..66 -> second word 32'h00006655; ACK follows; with BIG_ENDIAN=1 the first word is 32'h11223344.
REQ-044 Header 00 00 00 00 -> ACK immediately, no program words; then data 01 02 03 04 -> word 32'h04030201 with word_is_instr=0.
REQ-045 FIFO_DEPTH=2, word_ready=0, 3 data words -> first two retained, overrun=1; then word_ready=1 -> exactly two pops in order.
REQ-046 reset pulsed low after 2 program bytes -> all outputs reach reset values asynchronously; a full sequence afterwards loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the loader state enumeration and the default handshake bytes
// exchanged with the host.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_SIZE = 3'd1,
        ST_PROG = 3'd2,
        ST_ACK  = 3'd3,
        ST_DATA = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h99;
    localparam logic [7:0] DEFAULT_ACK_BYTE  = 8'haa;

endpackage

// File: rtl/loader_fifo.sv
// Small first-word-fall-through FIFO buffering assembled words.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and word to store
//   pop_ready           consumer takes the head word when head_valid is high
//   head_valid          FIFO not empty
//   head_data           current head entry
//   overrun             sticky: a push was refused because the FIFO was full
// A push and a pop in the same cycle both succeed, even when full: the
// slot being vacated by the pop is the one the push writes.
module loader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             overrun_reg;
    logic             full;
    logic             pop;
    logic             accept;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign head_valid = (wr_ptr_reg != rd_ptr_reg);
    assign full       = ((wr_ptr_reg - rd_ptr_reg) == (AW+1)'(DEPTH));
    assign pop        = head_valid && pop_ready;
    assign accept     = push && (!full || pop);
    assign head_data  = mem[rd_ptr_reg[AW-1:0]];
    assign overrun    = overrun_reg;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            if (push && !accept) begin
                overrun_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader front end.
// Announces itself with SYNC_BYTE every INTERVAL cycles until the host
// answers, then reads a little-endian byte-count header, assembles that
// many program bytes into words (flagged as instructions), acknowledges
// with ACK_BYTE and finally streams every following full word as data.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_ready, rdata   received-byte strobe and byte
//   tx_busy           UART transmitter busy
//   tx_start, sdata   transmit request pulse and byte (sdata held between pulses)
//   word_valid/ready  FIFO head handshake
//   word_data         FIFO head word
//   word_is_instr     head word came from the program section
//   program_loaded    high once the program has been acknowledged
//   overrun           sticky: a word was dropped on a full FIFO
module uart_loader
    import loader_pkg::*;
#(
    parameter int         WORD_BYTES = 4,
    parameter int         SIZE_BYTES = 4,
    parameter int         INTERVAL   = 100,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter logic [7:0] ACK_BYTE   = DEFAULT_ACK_BYTE,
    parameter bit         BIG_ENDIAN = 1'b0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_ready,
    input  logic [7:0]              rdata,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              sdata,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic                    word_is_instr,
    output logic                    program_loaded,
    output logic                    overrun
);

    localparam int WW     = 8 * WORD_BYTES;
    localparam int CW     = 8 * SIZE_BYTES;
    localparam int CNT_W  = (INTERVAL < 1) ? 1 : $clog2(INTERVAL + 1);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SI_W   = (SIZE_BYTES > 1) ? $clog2(SIZE_BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(WORD_BYTES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [SI_W-1:0]   size_idx_reg;
    logic [CW-1:0]     count_reg;
    logic [WW-1:0]     word_reg;
    logic [7:0]        sdata_reg;

    logic [CW-1:0]     count_acc;
    logic [CW-1:0]     remaining_dec;
    logic              size_last;
    logic              lane_last;
    logic [LANE_W-1:0] lane_pos;
    logic [WW-1:0]     word_new;
    logic [7:0]        tx_byte;
    logic              push;
    logic              push_instr;
    logic [WW:0]       head_data;

    // Header bytes arrive least significant first whatever the word order.
    assign count_acc     = count_reg | (CW'(rdata) << (8 * size_idx_reg));
    assign remaining_dec = count_reg - CW'(1);
    assign size_last     = (size_idx_reg == SI_W'(SIZE_BYTES - 1));
    assign lane_last     = (lane_reg == LANE_MAX);
    assign lane_pos      = BIG_ENDIAN ? (LANE_MAX - lane_reg) : lane_reg;

    // Lane 0 starts a fresh word, so lanes not yet written read as zero;
    // a short final program word is therefore zero-filled for free.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        assign word_new[8*gi +: 8] = (lane_pos == LANE_W'(gi)) ? rdata :
                                     ((lane_reg == '0) ? 8'h00 : word_reg[8*gi +: 8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SYNC: if (rx_ready) state_next = ST_SIZE;
            ST_SIZE: if (rx_ready && size_last)
                         state_next = (count_acc == '0) ? ST_ACK : ST_PROG;
            ST_PROG: if (rx_ready && (remaining_dec == '0)) state_next = ST_ACK;
            ST_ACK:  if (!tx_busy) state_next = ST_DATA;
            ST_DATA: state_next = ST_DATA;
            default: state_next = ST_SYNC;
        endcase
    end

    // tx_start is combinational on ~tx_busy so it can never overlap busy;
    // sdata shows the new byte in the pulse cycle and holds it afterwards.
    always_comb begin
        tx_start   = 1'b0;
        tx_byte    = sdata_reg;
        push       = 1'b0;
        push_instr = 1'b0;
        case (state_reg)
            ST_SYNC: if ((cnt_reg == CNT_W'(INTERVAL)) && !tx_busy) begin
                         tx_start = 1'b1;
                         tx_byte  = SYNC_BYTE;
                     end
            ST_PROG: if (rx_ready && (lane_last || (remaining_dec == '0))) begin
                         push       = 1'b1;
                         push_instr = 1'b1;
                     end
            ST_ACK:  if (!tx_busy) begin
                         tx_start = 1'b1;
                         tx_byte  = ACK_BYTE;
                     end
            ST_DATA: if (rx_ready && lane_last) push = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            lane_reg     <= '0;
            size_idx_reg <= '0;
            count_reg    <= '0;
            word_reg     <= '0;
            sdata_reg    <= '0;
        end else begin
            sdata_reg <= tx_byte;
            case (state_reg)
                ST_SYNC: begin
                    // Saturating: waits at INTERVAL while the sender is busy.
                    if (tx_start) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg != CNT_W'(INTERVAL)) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (rx_ready) begin
                        size_idx_reg <= '0;
                        count_reg    <= '0;
                    end
                end
                ST_SIZE: if (rx_ready) begin
                    count_reg    <= count_acc;
                    size_idx_reg <= size_idx_reg + SI_W'(1);
                    lane_reg     <= '0;
                end
                ST_PROG: if (rx_ready) begin
                    count_reg <= remaining_dec;
                    word_reg  <= word_new;
                    lane_reg  <= (lane_last || (remaining_dec == '0)) ? '0 : lane_reg + LANE_W'(1);
                end
                ST_ACK: lane_reg <= '0;
                ST_DATA: if (rx_ready) begin
                    word_reg <= word_new;
                    lane_reg <= lane_last ? '0 : lane_reg + LANE_W'(1);
                end
                default: ;
            endcase
        end
    end

    loader_fifo #(
        .WIDTH (WW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ({push_instr, word_new}),
        .pop_ready  (word_ready),
        .head_valid (word_valid),
        .head_data  (head_data),
        .overrun    (overrun)
    );

    assign sdata          = tx_byte;
    assign word_data      = head_data[WW-1:0];
    assign word_is_instr  = head_data[WW];
    assign program_loaded = (state_reg == ST_DATA);

endmodule
